// File: rtl/mode6_operand_feeder.sv
// Operand feeder for the fp16 mode-6 subtract stage.
// Streams (x - max) beats from the buffer, each paired with the latched ln(sum) operand.
module mode6_operand_feeder #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   base_addr,
  input  logic [ADDRWIDTH-1:0]   beats_m1,
  input  logic [DATAWIDTH-1:0]   logsum_in,
  input  logic                   logsum_valid,
  output logic                   mem_rd_en,
  output logic [ADDRWIDTH-1:0]   mem_rd_addr,
  input  logic [4*DATAWIDTH-1:0] mem_rd_data,
  output logic [DATAWIDTH-1:0]   a_out0,
  output logic [DATAWIDTH-1:0]   a_out1,
  output logic [DATAWIDTH-1:0]   a_out2,
  output logic [DATAWIDTH-1:0]   a_out3,
  output logic [DATAWIDTH-1:0]   b_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int WW = 4 * DATAWIDTH;
  localparam logic [ADDRWIDTH-1:0] ONE_A = 1;
  localparam logic [ADDRWIDTH:0]   ONE_I = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LS,
    STREAM,
    DONE
  } state_t;

  state_t               state_q;
  logic [WW-1:0]        q_mem_q [2];
  logic                 q_head_q;
  logic                 q_tail_q;
  logic [1:0]           q_cnt_q;
  logic                 inflight_q;
  logic [ADDRWIDTH-1:0] ptr_q;
  logic [ADDRWIDTH:0]   iss_rem_q;
  logic [ADDRWIDTH-1:0] acc_rem_q;
  logic [DATAWIDTH-1:0] b_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic [1:0]    occ_after;
  logic [WW-1:0] head;

  // Issue only while the queue plus the in-flight read leave room.
  always_comb begin
    pop       = (q_cnt_q != 2'd0) && out_ready;
    push      = inflight_q;
    occ_after = q_cnt_q - {1'b0, pop};
    issue     = (state_q == STREAM)
             && (iss_rem_q != '0)
             && ((occ_after + {1'b0, inflight_q}) < 2'd2);
    head      = q_mem_q[q_head_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      q_mem_q[0] <= '0;
      q_mem_q[1] <= '0;
      q_head_q   <= 1'b0;
      q_tail_q   <= 1'b0;
      q_cnt_q    <= 2'd0;
      inflight_q <= 1'b0;
      ptr_q      <= '0;
      iss_rem_q  <= '0;
      acc_rem_q  <= '0;
      b_q        <= '0;
    end else begin
      inflight_q <= issue;
      if (push) begin
        q_mem_q[q_tail_q] <= mem_rd_data;
        q_tail_q          <= ~q_tail_q;
      end
      if (pop)
        q_head_q <= ~q_head_q;
      q_cnt_q <= q_cnt_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        ptr_q     <= ptr_q + ONE_A;
        iss_rem_q <= iss_rem_q - ONE_I;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q     <= base_addr;
            iss_rem_q <= {1'b0, beats_m1} + ONE_I;
            acc_rem_q <= beats_m1;
            if (logsum_valid) begin
              b_q     <= logsum_in;
              state_q <= STREAM;
            end else begin
              state_q <= WAIT_LS;
            end
          end
        end
        WAIT_LS: begin
          if (logsum_valid) begin
            b_q     <= logsum_in;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (pop) begin
            if (acc_rem_q == '0)
              state_q <= DONE;
            else
              acc_rem_q <= acc_rem_q - ONE_A;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = ptr_q;
  assign a_out0      = head[DATAWIDTH-1:0];
  assign a_out1      = head[2*DATAWIDTH-1:DATAWIDTH];
  assign a_out2      = head[3*DATAWIDTH-1:2*DATAWIDTH];
  assign a_out3      = head[4*DATAWIDTH-1:3*DATAWIDTH];
  assign b_out       = b_q;
  assign out_valid   = (q_cnt_q != 2'd0);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: doc/mode6_operand_feeder.md
Name: mode6_operand_feeder

Overview:
- Stage directly upstream of the four-lane fp16 mode-6 subtract stage.
- Streams the (x − max) vector out of the intermediate buffer as 4-lane beats.
- Pairs every beat with the latched scalar ln(sum) operand, which drives b_inp of the subtract stage.
- Provides a valid/ready handshake, absorbs the buffer's 1-cycle read latency with a 2-entry queue, and reports completion.

Parameters:
- DATAWIDTH, 16, width of one fp16 lane and of the scalar operand.
- ADDRWIDTH, 8, buffer word address width; one word holds 4 lanes.

Ports:
- clk  input  1  clock, all logic rising-edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle request to stream one vector; honoured only in IDLE.
- base_addr  input  ADDRWIDTH  first buffer word, sampled on an accepted start.
- beats_m1  input  ADDRWIDTH  number of beats minus 1, sampled on an accepted start.
- logsum_in  input  DATAWIDTH  scalar subtrahend from the ln stage.
- logsum_valid  input  1  logsum_in is valid this cycle.
- mem_rd_en  output  1  buffer read strobe.
- mem_rd_addr  output  ADDRWIDTH  buffer read address.
- mem_rd_data  input  4*DATAWIDTH  read data, valid exactly 1 cycle after mem_rd_en. Lane0 = [15:0], lane3 = [63:48].
- a_out0..a_out3  output  DATAWIDTH each  lane operands to the subtract stage.
- b_out  output  DATAWIDTH  latched scalar operand to the subtract stage.
- out_valid  output  1  beat present on a_out*/b_out.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last beat is accepted.

Behaviour:
- Reset (reset_n low at clk edge):
  - state = IDLE.
  - All outputs 0: mem_rd_en, mem_rd_addr, a_out*, b_out, out_valid, busy, done.
  - Queue emptied, in-flight flag cleared, counters cleared.
  - Any read in flight at reset is discarded; its returning data is never written to the queue.
  - Reset takes priority over every other event.
- States: IDLE, WAIT_LS, STREAM, DONE.
- IDLE:
  - start=1 latches base_addr into the read pointer and beats_m1 into the issue and accept counters.
  - If logsum_valid=1 in the same cycle: latch logsum_in into b_out and go to STREAM. Otherwise go to WAIT_LS.
  - start while not IDLE is ignored.
- WAIT_LS: on logsum_valid=1, latch logsum_in into b_out and go to STREAM.
- b_out holds its value until the next latch. logsum_valid outside IDLE/WAIT_LS is ignored.
- STREAM, read issue:
  - Condition: issue counter not exhausted AND (queue occupancy + in-flight read) < 2, with the occupancy counted after this cycle's pop.
  - On issue: mem_rd_en=1, mem_rd_addr = pointer, then pointer increments. Pointer wraps modulo 2^ADDRWIDTH.
  - Result: at most 1 read in flight, and the queue never overflows.
- STREAM, data return: mem_rd_data is pushed into the queue on the cycle after mem_rd_en.
- Output path:
  - a_out*/out_valid reflect the queue head directly (registered queue storage, no combinational path from mem_rd_data).
  - A beat transfers when out_valid && out_ready. Push and pop may occur in the same cycle.
  - With out_ready held high, throughput is 1 beat/cycle after a 2-cycle initial latency: first read issued the cycle after entering STREAM, out_valid the cycle after the data returns.
  - out_valid, once asserted, stays asserted and a_out* stay stable until the beat is accepted.
- Last beat: when the accept counter reaches the final beat and that beat transfers, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. start in DONE is ignored.
- beats_m1 = 0 streams exactly one beat. beats_m1 = 2^ADDRWIDTH−1 streams the full buffer, wrapping the pointer back to base_addr.
- No arithmetic is performed on the data. Lanes are passed bit-exact.

Test Plan:
- Basic stream:
  - Stimulus: buffer words 0x10..0x13 hold lanes {k, k+1, k+2, k+3}; start with base=0x10, beats_m1=3, logsum_valid=1, logsum_in=0x3C00; out_ready=1.
  - Required: 4 beats on consecutive cycles in address order; b_out=0x3C00 on all beats; done pulses on the cycle after the 4th accept; busy falls the following cycle.
- Late logsum:
  - Stimulus: start with logsum_valid=0; logsum_valid asserted 5 cycles later with 0x4200.
  - Required: no mem_rd_en before that cycle; all beats carry b_out=0x4200.
- Backpressure:
  - Stimulus: beats_m1=7; out_ready toggles 1,0,0,1,0,1…
  - Required: no beat lost or duplicated; never more than 2 words buffered; a_out* stable while stalled; 8 accepted beats in address order.
- Wrap and minimum length:
  - Stimulus: base=0xFE, beats_m1=3.
  - Required: read addresses 0xFE, 0xFF, 0x00, 0x01.
  - Stimulus: beats_m1=0.
  - Required: exactly 1 beat, then done.
- Ignored start:
  - Stimulus: start pulsed mid-stream with different base_addr.
  - Required: current stream unaffected.
- Reset mid-stream:
  - Stimulus: reset_n low for 1 cycle with a read in flight and out_valid=1.
  - Required: all outputs 0 next cycle; IDLE; no stale beat ever appears; a new start streams normally.
